mv_stream_loader: RTL

Upstream loader for the 6-lane matrix-vector engine. It accepts one AXI-Stream burst per job: the vector words first, then the matrix words. It writes them into the vector BRAM (addresses 0..NB-1) and the matrix BRAM (addresses 0..NB*NB-1), where NB = ceil(width/6). It then holds `load_done` so software can raise the controller's `running`. Each stream beat is one BRAM word holding 6 lanes.

---
 rtl/mv_stream_loader_if.sv | 13 +
 rtl/mv_stream_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mv_stream_loader_if.sv
// AXI-Stream subset carrying job beats into mv_stream_loader.
// The sender takes the master modport and the loader takes the slave modport.
interface mv_stream_loader_if #(
   parameter int unsigned DATA_W = 72
);
   logic [DATA_W-1:0] s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic              s_tlast;

   modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
   modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

// File: rtl/mv_stream_loader.sv
// Stream loader that fills the vector BRAM and then the NBxNB matrix BRAM from one burst per job.
// Optional macro MV_LOADER_TLAST_CHECK_EN turns a misplaced s_tlast into an ERR outcome.
module mv_stream_loader #(
   parameter int unsigned DATA_W    = 72,
   parameter int unsigned MAX_WIDTH = 384
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [8:0]        width,
   input  logic              start,
   input  logic              abort,
   mv_stream_loader_if.slave s,
   output logic              mbram_en,
   output logic              mbram_we,
   output logic [11:0]       mbram_addr,
   output logic [DATA_W-1:0] mbram_din,
   output logic              vbram_en,
   output logic              vbram_we,
   output logic [9:0]        vbram_addr,
   output logic [DATA_W-1:0] vbram_din,
   output logic              busy,
   output logic              load_done,
   output logic              error
);

   localparam logic [8:0] MAX_W9 = MAX_WIDTH[8:0];

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SIZE,
      ST_LOAD_V,
      ST_LOAD_M,
      ST_DONE,
      ST_ERR
   } state_e;

   state_e            state_q, state_d;
   logic [8:0]        width_q, width_d;
   logic [9:0]        blk_cnt_q, blk_cnt_d;
   logic [6:0]        nb_q, nb_d;
   logic [6:0]        row_q, row_d;
   logic [6:0]        col_q, col_d;
   logic [9:0]        v_idx_q, v_idx_d;
   logic [11:0]       m_idx_q, m_idx_d;
   logic              tready_q, tready_d;
   logic              mwe_q, mwe_d;
   logic [11:0]       maddr_q, maddr_d;
   logic [DATA_W-1:0] mdin_q, mdin_d;
   logic              vwe_q, vwe_d;
   logic [9:0]        vaddr_q, vaddr_d;
   logic [DATA_W-1:0] vdin_q, vdin_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              hs;
   logic              v_last;
   logic              m_last;
   logic              tlast_bad;

   // tready_q is only ever high in LOAD_V/LOAD_M, so hs alone qualifies a beat.
   assign hs     = s.s_tvalid && tready_q;
   assign v_last = ({3'b000, nb_q} == (v_idx_q + 10'd1));
   assign m_last = (row_q == (nb_q - 7'd1)) && (col_q == (nb_q - 7'd1));

`ifdef MV_LOADER_TLAST_CHECK_EN
   assign tlast_bad = hs && (s.s_tlast != ((state_q == ST_LOAD_M) && m_last));
`else
   logic unused_tlast;
   assign unused_tlast = s.s_tlast;
   assign tlast_bad    = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      width_d   = width_q;
      blk_cnt_d = blk_cnt_q;
      nb_d      = nb_q;
      row_d     = row_q;
      col_d     = col_q;
      v_idx_d   = v_idx_q;
      m_idx_d   = m_idx_q;
      mwe_d     = 1'b0;
      maddr_d   = maddr_q;
      mdin_d    = mdin_q;
      vwe_d     = 1'b0;
      vaddr_d   = vaddr_q;
      vdin_d    = vdin_q;

      if (abort) begin
         state_d   = ST_IDLE;
         blk_cnt_d = '0;
         nb_d      = '0;
         row_d     = '0;
         col_d     = '0;
         v_idx_d   = '0;
         m_idx_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  width_d   = width;
                  blk_cnt_d = '0;
                  nb_d      = '0;
                  row_d     = '0;
                  col_d     = '0;
                  v_idx_d   = '0;
                  m_idx_d   = '0;
                  state_d   = (width > MAX_W9) ? ST_ERR : ST_SIZE;
               end
            end
            // NB = ceil(width/6) by repeated addition: one block per cycle.
            ST_SIZE: begin
               if (blk_cnt_q >= {1'b0, width_q}) begin
                  state_d = (nb_q == 7'd0) ? ST_DONE : ST_LOAD_V;
               end else begin
                  blk_cnt_d = blk_cnt_q + 10'd6;
                  nb_d      = nb_q + 7'd1;
               end
            end
            ST_LOAD_V: begin
               if (hs) begin
                  vwe_d   = 1'b1;
                  vaddr_d = v_idx_q;
                  vdin_d  = s.s_tdata;
                  v_idx_d = v_idx_q + 10'd1;
                  if (v_last) state_d = ST_LOAD_M;
                  if (tlast_bad) state_d = ST_ERR;
               end
            end
            ST_LOAD_M: begin
               if (hs) begin
                  mwe_d   = 1'b1;
                  maddr_d = m_idx_q;
                  mdin_d  = s.s_tdata;
                  m_idx_d = m_idx_q + 12'd1;
                  if (col_q == (nb_q - 7'd1)) begin
                     col_d = '0;
                     row_d = row_q + 7'd1;
                  end else begin
                     col_d = col_q + 7'd1;
                  end
                  if (m_last) state_d = ST_DONE;
                  if (tlast_bad) state_d = ST_ERR;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Ready lags LOAD_V entry by a cycle and drops on the edge that leaves the load states.
      tready_d = ((state_q == ST_LOAD_V) || (state_q == ST_LOAD_M)) &&
                 ((state_d == ST_LOAD_V) || (state_d == ST_LOAD_M));
      busy_d   = (state_d == ST_SIZE) || (state_d == ST_LOAD_V) || (state_d == ST_LOAD_M);
      done_d   = (state_d == ST_DONE);
      err_d    = (state_d == ST_ERR);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         width_q   <= '0;
         blk_cnt_q <= '0;
         nb_q      <= '0;
         row_q     <= '0;
         col_q     <= '0;
         v_idx_q   <= '0;
         m_idx_q   <= '0;
         tready_q  <= 1'b0;
         mwe_q     <= 1'b0;
         maddr_q   <= '0;
         mdin_q    <= '0;
         vwe_q     <= 1'b0;
         vaddr_q   <= '0;
         vdin_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         width_q   <= width_d;
         blk_cnt_q <= blk_cnt_d;
         nb_q      <= nb_d;
         row_q     <= row_d;
         col_q     <= col_d;
         v_idx_q   <= v_idx_d;
         m_idx_q   <= m_idx_d;
         tready_q  <= tready_d;
         mwe_q     <= mwe_d;
         maddr_q   <= maddr_d;
         mdin_q    <= mdin_d;
         vwe_q     <= vwe_d;
         vaddr_q   <= vaddr_d;
         vdin_q    <= vdin_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign s.s_tready = tready_q;
   assign mbram_en   = mwe_q;
   assign mbram_we   = mwe_q;
   assign mbram_addr = maddr_q;
   assign mbram_din  = mdin_q;
   assign vbram_en   = vwe_q;
   assign vbram_we   = vwe_q;
   assign vbram_addr = vaddr_q;
   assign vbram_din  = vdin_q;
   assign busy       = busy_q;
   assign load_done  = done_q;
   assign error      = err_q;

endmodule
